// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and self-check of a combinational block
//
// Steps drive through every vector 0 .. 2**N_IN-1, holds each for SETTLE
// cycles, samples y_in in a following SAMPLE cycle, and compares the observed
// table with the expected table captured when start is accepted.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a sweep (only honoured in IDLE)
//   expected        expected table, bit k = expected y for vector k
//   drive           registered stimulus to the block under test (vector k = binary k)
//   y_in            output of the block under test
//   busy            high while vectors are being driven and sampled
//   done            one-cycle pulse when the sweep completes
//   table_out       observed table, bit k = sampled y_in for vector k
//   pass            table_out matches the captured expected table (valid from done)
//   mismatch_count  number of mismatching vectors
//   first_fail      lowest failing vector index
//   fail_valid      first_fail holds a valid index
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      drive,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_count,
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_valid
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NV-1:0]   exp_r;
    logic [NV-1:0]   table_next;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            last_vec;
    logic            settled;
    logic            miss;

    assign last_vec = (idx == {N_IN{1'b1}});
    assign settled  = (cnt == CW'(SETTLE - 1));
    assign miss     = (y_in != exp_r[idx]);

    always_comb begin
        state_next      = state;
        busy            = 1'b0;
        done            = 1'b0;
        // Table including the sample being taken this cycle, so pass can be
        // registered on the same edge that writes the final bit.
        table_next      = table_out;
        table_next[idx] = y_in;
        case (state)
            IDLE: begin
                if (start) state_next = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (settled) state_next = SAMPLE;
            end
            SAMPLE: begin
                busy       = 1'b1;
                state_next = last_vec ? DONE : HOLD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_r          <= '0;
            table_out      <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
            fail_valid     <= 1'b0;
            idx            <= '0;
            drive          <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_r          <= expected;
                        table_out      <= '0;
                        pass           <= 1'b0;
                        mismatch_count <= '0;
                        first_fail     <= '0;
                        fail_valid     <= 1'b0;
                        idx            <= '0;
                        drive          <= '0;
                        cnt            <= '0;
                    end
                end
                HOLD: begin
                    cnt <= cnt + 1'b1;
                end
                SAMPLE: begin
                    table_out <= table_next;
                    if (miss) begin
                        mismatch_count <= mismatch_count + 1'b1;
                        if (!fail_valid) begin
                            first_fail <= idx;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        pass <= (table_next == exp_r);
                    end else begin
                        idx   <= idx + 1'b1;
                        drive <= idx + 1'b1;
                        cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
